bus_wr_decoder: RTL and testbench
=================================

Name: bus_wr_decoder

Overview:
- Write-side counterpart of the processor read-data mux.
- On a processor store it decodes the address and registers address and data for one cycle. It then issues single-cycle write strobes to data RAM and UARTs A/B/C.
- It holds the LED and seven-segment output registers.
- Writes to read-only, unmapped or misaligned addresses are flagged in a sticky error register.

Parameters:
- RAM_BASE, 32'h1000, first byte address of the data RAM window.
- RAM_END, 32'h13FC, exclusive upper bound of the RAM window.
- LED_RST, 32'h0, reset value of led_o.
- SEG_RST, 32'h0, reset value of seg_o.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  reset, asynchronous, active-low
- we_i  in  1  processor store request, sampled every rising edge
- addr_i  in  32  store byte address
- wdata_i  in  32  store data
- err_clr_i  in  1  clears err_o and err_addr_o
- wdata_o  out  32  registered store data, shared by all strobe targets
- ram_we_o  out  1  RAM write strobe
- ram_addr_o  out  8  RAM word index, (addr_i - RAM_BASE) >> 2
- uart_we_o  out  3  per-UART write strobe: bit0 = A, bit1 = B, bit2 = C
- uart_reg_o  out  1  UART register select: 0 = control (+0x0), 1 = tx data (+0x8)
- led_o  out  32  LED register
- seg_o  out  32  seven-segment register
- err_o  out  1  sticky illegal-write flag
- err_addr_o  out  32  address of the first illegal write since the last clear

Behaviour:
- Reset (rst_n_i low, asynchronous) sets:
  - all strobes to 0, wdata_o to 0, ram_addr_o to 0, uart_reg_o to 0;
  - led_o to LED_RST, seg_o to SEG_RST;
  - err_o to 0, err_addr_o to 0.
- Reset mid-write discards the pending strobe.
- Decode, evaluated only when we_i = 1 at a rising edge:
  - RAM_BASE <= addr < RAM_END and addr[1:0] = 0 -> RAM.
  - 0x2004 -> LED.
  - 0x2008 -> seven-segment.
  - 0x2010 / 0x2018 -> UART A control / tx data.
  - 0x2020 / 0x2028 -> UART B control / tx data.
  - 0x2030 / 0x2038 -> UART C control / tx data.
  - 0x2000 (switches), 0x201C / 0x202C / 0x203C (rx data, read-only), any other address, and any misaligned address -> illegal.
- Latency and strobe shape:
  - Strobes, ram_addr_o, uart_reg_o and wdata_o are valid in the cycle after the store is sampled.
  - Exactly one strobe is high, for exactly one cycle.
  - With we_i = 0, every strobe is 0 in the next cycle.
  - ram_addr_o, uart_reg_o and wdata_o hold their last value while idle.
- led_o / seg_o: loaded with wdata_i at the sampling edge, visible the next cycle. They hold their value otherwise; no strobe is exported for them.
- Back-to-back stores: one store per cycle at full throughput, with no stall or back-pressure. Consecutive RAM stores produce ram_we_o high for consecutive cycles.
- Illegal write:
  - No strobe; no register changes.
  - If err_o = 0: err_o is set to 1 and err_addr_o captures addr_i in the next cycle.
  - If err_o = 1 already: err_addr_o is kept (first error wins).
- err_clr_i clears err_o and err_addr_o at the next edge. If an illegal write is sampled in the same cycle, the new error wins: err_o stays 1 and err_addr_o takes the new address.
- RAM boundaries:
  - 0x13F8 is legal, word index 254.
  - 0x13FC is illegal.
  - 0x0FFC is illegal.
- Arithmetic: the index is the 32-bit subtraction addr_i - RAM_BASE, truncated to bits [9:2]. Only aligned in-window addresses reach this path.

Decomposition:
- Package bus_addr_pkg:
  - address constants for SW, LED, SEG, and UART A/B/C bases;
  - UART register offsets (CTRL 0x0, TX 0x8, RX 0xC);
  - RAM_BASE / RAM_END defaults;
  - enum wr_target_e {TGT_NONE, TGT_RAM, TGT_LED, TGT_SEG, TGT_UART_A, TGT_UART_B, TGT_UART_C, TGT_ILLEGAL}.
  - The package is shared with the read mux so both sides use one address map.
- One sub-module, bus_wr_addr_decode: purely combinational, addr_i -> wr_target_e plus uart_reg select.
- The top level owns all registers.

Test Plan:
- Reset: hold rst_n_i low mid-stream -> all outputs at reset values in the same cycle, no strobe after release until a new we_i.
- RAM edges: store 0x1000 / 0xAAAA5555 -> next cycle ram_we_o = 1, ram_addr_o = 0, wdata_o = 0xAAAA5555. Store 0x13F8 -> ram_addr_o = 254. Store 0x13FC -> no strobe, err_o = 1, err_addr_o = 0x13FC.
- Peripheral registers: store 0x2004 / 0xF0 then 0x2008 / 0x7F on consecutive cycles -> led_o = 0xF0 one cycle after the first store, seg_o = 0x7F the cycle after; no RAM or UART strobe.
- UART stores: 0x2028 / 0x41 -> uart_we_o = 3'b010, uart_reg_o = 1 for one cycle. 0x2030 -> uart_we_o = 3'b100, uart_reg_o = 0. 0x203C -> error, no strobe.
- Sticky error: stores 0x2000, then 0x3000, then 0x1002 -> err_o = 1, err_addr_o stays 0x2000. Assert err_clr_i in the same cycle as store 0x5000 -> err_o = 1, err_addr_o = 0x5000.
- Throughput: four consecutive RAM stores 0x1000..0x100C -> ram_we_o high four consecutive cycles with indices 0, 1, 2, 3; then we_i = 0 -> ram_we_o = 0.

Source files
------------

// File: rtl/bus_addr_pkg.sv
// ---------------------------------------------------------------------------
// bus_addr_pkg
//
// Purpose:
//   Single source of truth for the processor address map.
//   It is shared by the write decoder and the read-data mux, so both sides
//   always agree on where each peripheral lives.
//
// Contents:
//   - peripheral addresses (switches, LED, seven-segment, UART A/B/C bases)
//   - UART register offsets relative to a UART base
//   - default RAM window bounds
//   - wr_target_e : result of decoding a store address
//   - uart_onehot : maps a UART target onto the per-UART strobe vector
// ---------------------------------------------------------------------------
package bus_addr_pkg;

  // Memory-mapped peripheral addresses (byte addresses)
  localparam logic [31:0] SW_ADDR     = 32'h0000_2000;
  localparam logic [31:0] LED_ADDR    = 32'h0000_2004;
  localparam logic [31:0] SEG_ADDR    = 32'h0000_2008;
  localparam logic [31:0] UART_A_BASE = 32'h0000_2010;
  localparam logic [31:0] UART_B_BASE = 32'h0000_2020;
  localparam logic [31:0] UART_C_BASE = 32'h0000_2030;

  // UART register offsets
  localparam logic [31:0] UART_CTRL_OFS = 32'h0000_0000;
  localparam logic [31:0] UART_TX_OFS   = 32'h0000_0008;
  localparam logic [31:0] UART_RX_OFS   = 32'h0000_000C;

  // Data RAM window: [RAM_BASE_DEF, RAM_END_DEF), word aligned
  localparam logic [31:0] RAM_BASE_DEF = 32'h0000_1000;
  localparam logic [31:0] RAM_END_DEF  = 32'h0000_13FC;

  typedef enum logic [2:0] {
    TGT_NONE,
    TGT_RAM,
    TGT_LED,
    TGT_SEG,
    TGT_UART_A,
    TGT_UART_B,
    TGT_UART_C,
    TGT_ILLEGAL
  } wr_target_e;

  // Bit 0 = UART A, bit 1 = UART B, bit 2 = UART C; anything else gives 0
  function automatic logic [2:0] uart_onehot(wr_target_e tgt);
    logic [2:0] strobe;
    case (tgt)
      TGT_UART_A: strobe = 3'b001;
      TGT_UART_B: strobe = 3'b010;
      TGT_UART_C: strobe = 3'b100;
      default:    strobe = 3'b000;
    endcase
    return strobe;
  endfunction

endpackage

// File: rtl/bus_wr_decoder_if.sv
// ---------------------------------------------------------------------------
// bus_wr_decoder_if
//
// Purpose:
//   Processor store request bundle presented to the write decoder.
//
// Signals:
//   we    : store request, sampled on every rising clock edge
//   addr  : store byte address
//   wdata : store data
//
// Modports:
//   master : processor side, drives the request
//   slave  : decoder side, receives the request
// ---------------------------------------------------------------------------
interface bus_wr_decoder_if;

  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;

  modport master (output we, output addr, output wdata);
  modport slave  (input  we, input  addr, input  wdata);

endinterface

// File: rtl/bus_wr_addr_decode.sv
// ---------------------------------------------------------------------------
// bus_wr_addr_decode
//
// Purpose:
//   Purely combinational store-address decoder. It classifies a byte address
//   into a write target and, for UART targets, selects control or tx data.
//   The decoder does not look at the store request; the caller gates with we.
//
// Parameters:
//   RAM_BASE : first byte address of the data RAM window
//   RAM_END  : exclusive upper bound of the data RAM window
//
// Ports:
//   addr_i     in  32  store byte address
//   tgt_o      out     decoded target (never TGT_NONE)
//   uart_reg_o out  1  0 = UART control register, 1 = UART tx data register
// ---------------------------------------------------------------------------
module bus_wr_addr_decode
  import bus_addr_pkg::*;
#(
  parameter logic [31:0] RAM_BASE = RAM_BASE_DEF,
  parameter logic [31:0] RAM_END  = RAM_END_DEF
) (
  input  logic [31:0] addr_i,
  output wr_target_e  tgt_o,
  output logic        uart_reg_o
);

  // Misaligned addresses are illegal regardless of the region they fall in.
  // The RAM window is checked first as a range; every other legal target is
  // a single exact address. Switches and the UART rx data registers are
  // read-only, so they are listed explicitly as illegal for clarity.
  always_comb begin
    tgt_o      = TGT_ILLEGAL;
    uart_reg_o = 1'b0;
    if (addr_i[1:0] == 2'b00) begin
      if ((addr_i >= RAM_BASE) && (addr_i < RAM_END)) begin
        tgt_o = TGT_RAM;
      end else begin
        case (addr_i)
          LED_ADDR: tgt_o = TGT_LED;
          SEG_ADDR: tgt_o = TGT_SEG;
          UART_A_BASE + UART_CTRL_OFS: tgt_o = TGT_UART_A;
          UART_A_BASE + UART_TX_OFS: begin
            tgt_o      = TGT_UART_A;
            uart_reg_o = 1'b1;
          end
          UART_B_BASE + UART_CTRL_OFS: tgt_o = TGT_UART_B;
          UART_B_BASE + UART_TX_OFS: begin
            tgt_o      = TGT_UART_B;
            uart_reg_o = 1'b1;
          end
          UART_C_BASE + UART_CTRL_OFS: tgt_o = TGT_UART_C;
          UART_C_BASE + UART_TX_OFS: begin
            tgt_o      = TGT_UART_C;
            uart_reg_o = 1'b1;
          end
          SW_ADDR,
          UART_A_BASE + UART_RX_OFS,
          UART_B_BASE + UART_RX_OFS,
          UART_C_BASE + UART_RX_OFS: tgt_o = TGT_ILLEGAL;
          default: tgt_o = TGT_ILLEGAL;
        endcase
      end
    end
  end

endmodule

// File: rtl/bus_wr_decoder.sv
// ---------------------------------------------------------------------------
// bus_wr_decoder
//
// Purpose:
//   Write side of the processor bus. A store sampled on a rising edge is
//   decoded and turned into a single-cycle write strobe (data RAM or one of
//   UARTs A/B/C) in the following cycle, together with the registered address
//   and data. LED and seven-segment registers live here and load directly.
//   Stores to read-only, unmapped or misaligned addresses raise a sticky
//   error that records the first offending address.
//
// Parameters:
//   RAM_BASE : first byte address of the RAM window
//   RAM_END  : exclusive upper bound of the RAM window
//   LED_RST  : reset value of led_o
//   SEG_RST  : reset value of seg_o
//
// Ports:
//   clk_i       in      system clock
//   rst_n_i     in      asynchronous active-low reset
//   bus         slave   store request (we, addr, wdata)
//   err_clr_i   in   1  clears err_o / err_addr_o
//   wdata_o     out 32  registered store data for all strobe targets
//   ram_we_o    out  1  RAM write strobe
//   ram_addr_o  out  8  RAM word index
//   uart_we_o   out  3  per-UART strobe, bit0 = A, bit1 = B, bit2 = C
//   uart_reg_o  out  1  0 = control, 1 = tx data
//   led_o       out 32  LED register
//   seg_o       out 32  seven-segment register
//   err_o       out  1  sticky illegal-write flag
//   err_addr_o  out 32  first illegal address since the last clear
// ---------------------------------------------------------------------------
module bus_wr_decoder
  import bus_addr_pkg::*;
#(
  parameter logic [31:0] RAM_BASE = RAM_BASE_DEF,
  parameter logic [31:0] RAM_END  = RAM_END_DEF,
  parameter logic [31:0] LED_RST  = 32'h0,
  parameter logic [31:0] SEG_RST  = 32'h0
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  bus_wr_decoder_if.slave         bus,
  input  logic                    err_clr_i,
  output logic [31:0]             wdata_o,
  output logic                    ram_we_o,
  output logic [7:0]              ram_addr_o,
  output logic [2:0]              uart_we_o,
  output logic                    uart_reg_o,
  output logic [31:0]             led_o,
  output logic [31:0]             seg_o,
  output logic                    err_o,
  output logic [31:0]             err_addr_o
);

  wr_target_e  dec_tgt;
  logic        dec_uart_reg;
  wr_target_e  tgt;
  logic [7:0]  ram_index;
  logic        illegal;

  logic [31:0] wdata_q, wdata_d;
  logic        ram_we_q, ram_we_d;
  logic [7:0]  ram_addr_q, ram_addr_d;
  logic [2:0]  uart_we_q, uart_we_d;
  logic        uart_reg_q, uart_reg_d;
  logic [31:0] led_q, led_d;
  logic [31:0] seg_q, seg_d;
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;

  bus_wr_addr_decode #(
    .RAM_BASE (RAM_BASE),
    .RAM_END  (RAM_END)
  ) u_addr_decode (
    .addr_i     (bus.addr),
    .tgt_o      (dec_tgt),
    .uart_reg_o (dec_uart_reg)
  );

  // No store request means no target at all, which keeps the
  // next-state logic below free of separate we checks.
  assign tgt     = bus.we ? dec_tgt : TGT_NONE;
  assign illegal = (tgt == TGT_ILLEGAL);

  // Word index from the 32-bit offset into the window; only bits [9:2]
  // survive the truncation. Meaningful only for in-window aligned stores.
  assign ram_index = 8'((bus.addr - RAM_BASE) >> 2);

  always_comb begin
    wdata_d    = wdata_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    uart_we_d  = 3'b000;
    uart_reg_d = uart_reg_q;
    led_d      = led_q;
    seg_d      = seg_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;

    // Strobes default low every cycle so each lasts exactly one cycle;
    // address/data side registers only move when their target is written.
    case (tgt)
      TGT_RAM: begin
        ram_we_d   = 1'b1;
        ram_addr_d = ram_index;
        wdata_d    = bus.wdata;
      end
      TGT_LED: led_d = bus.wdata;
      TGT_SEG: seg_d = bus.wdata;
      TGT_UART_A, TGT_UART_B, TGT_UART_C: begin
        uart_we_d  = uart_onehot(tgt);
        uart_reg_d = dec_uart_reg;
        wdata_d    = bus.wdata;
      end
      default: ;
    endcase

    // First error wins, except that a clear in the same cycle as a new
    // illegal store lets the new address replace the old one.
    if (illegal) begin
      if (!err_q || err_clr_i) begin
        err_d      = 1'b1;
        err_addr_d = bus.addr;
      end
    end else if (err_clr_i) begin
      err_d      = 1'b0;
      err_addr_d = 32'h0;
    end
  end

  // Asynchronous reset also drops any strobe that was about to be issued.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wdata_q    <= 32'h0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= 8'h0;
      uart_we_q  <= 3'b000;
      uart_reg_q <= 1'b0;
      led_q      <= LED_RST;
      seg_q      <= SEG_RST;
      err_q      <= 1'b0;
      err_addr_q <= 32'h0;
    end else begin
      wdata_q    <= wdata_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      uart_we_q  <= uart_we_d;
      uart_reg_q <= uart_reg_d;
      led_q      <= led_d;
      seg_q      <= seg_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign wdata_o    = wdata_q;
  assign ram_we_o   = ram_we_q;
  assign ram_addr_o = ram_addr_q;
  assign uart_we_o  = uart_we_q;
  assign uart_reg_o = uart_reg_q;
  assign led_o      = led_q;
  assign seg_o      = seg_q;
  assign err_o      = err_q;
  assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_bus_wr_decoder.sv
// ---------------------------------------------------------------------------
// tb_bus_wr_decoder
//
// Self-checking bench for bus_wr_decoder: a directed vector table, a reset
// sequence in the middle of traffic, then randomized stores compared against
// an address-map reference model.
// ---------------------------------------------------------------------------
module tb_bus_wr_decoder;

  localparam int K_RAM  = 1;
  localparam int K_LED  = 2;
  localparam int K_SEG  = 3;
  localparam int K_UART = 4;
  localparam int K_ILL  = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        err_clr;
  logic [31:0] wdata_o;
  logic        ram_we_o;
  logic [7:0]  ram_addr_o;
  logic [2:0]  uart_we_o;
  logic        uart_reg_o;
  logic [31:0] led_o;
  logic [31:0] seg_o;
  logic        err_o;
  logic [31:0] err_addr_o;

  int checks = 0;
  int errors = 0;

  bus_wr_decoder_if bus_if ();

  bus_wr_decoder #(
    .RAM_BASE (32'h1000),
    .RAM_END  (32'h13FC),
    .LED_RST  (32'h0),
    .SEG_RST  (32'h0)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .bus        (bus_if),
    .err_clr_i  (err_clr),
    .wdata_o    (wdata_o),
    .ram_we_o   (ram_we_o),
    .ram_addr_o (ram_addr_o),
    .uart_we_o  (uart_we_o),
    .uart_reg_o (uart_reg_o),
    .led_o      (led_o),
    .seg_o      (seg_o),
    .err_o      (err_o),
    .err_addr_o (err_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          clr;
    bit          ram_we;
    logic [7:0]  ram_addr;
    logic [2:0]  uart_we;
    bit          uart_reg;
    logic [31:0] led;
    logic [31:0] seg;
    bit          err;
    logic [31:0] err_addr;
    bit          chk_wdata;
    logic [31:0] wdata_exp;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  logic [31:0] m_wdata, m_led, m_seg, m_err_addr;
  logic [7:0]  m_ram_idx;
  bit          m_ureg, m_err;

  logic [31:0] periph_list [12] = '{32'h2000, 32'h2004, 32'h2008, 32'h2010,
                                    32'h2018, 32'h201C, 32'h2020, 32'h2028,
                                    32'h202C, 32'h2030, 32'h2038, 32'h203C};
  logic [31:0] edge_list [4] = '{32'h0FFC, 32'h1000, 32'h13F8, 32'h13FC};

  task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic addVec(bit we, logic [31:0] addr, logic [31:0] wdata, bit clr,
                        bit ram_we, logic [7:0] ram_addr, logic [2:0] uart_we,
                        bit uart_reg, logic [31:0] led, logic [31:0] seg,
                        bit err, logic [31:0] err_addr, bit chk,
                        logic [31:0] wexp);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.clr = clr;
    v.ram_we = ram_we; v.ram_addr = ram_addr; v.uart_we = uart_we;
    v.uart_reg = uart_reg; v.led = led; v.seg = seg; v.err = err;
    v.err_addr = err_addr; v.chk_wdata = chk; v.wdata_exp = wexp;
    vecs.push_back(v);
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next
  // falling edge, i.e. half a cycle after the edge that consumed the store.
  task automatic applyStimulus(bit we, logic [31:0] addr, logic [31:0] wdata, bit clr);
    bus_if.we    = we;
    bus_if.addr  = addr;
    bus_if.wdata = wdata;
    err_clr      = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(string tag, vec_t v);
    checkVal({tag, " ram_we"},   32'(ram_we_o),   32'(v.ram_we));
    checkVal({tag, " ram_addr"}, 32'(ram_addr_o), 32'(v.ram_addr));
    checkVal({tag, " uart_we"},  32'(uart_we_o),  32'(v.uart_we));
    checkVal({tag, " uart_reg"}, 32'(uart_reg_o), 32'(v.uart_reg));
    checkVal({tag, " led"},      led_o,           v.led);
    checkVal({tag, " seg"},      seg_o,           v.seg);
    checkVal({tag, " err"},      32'(err_o),      32'(v.err));
    checkVal({tag, " err_addr"}, err_addr_o,      v.err_addr);
    if (v.chk_wdata) checkVal({tag, " wdata"}, wdata_o, v.wdata_exp);
  endtask

  // Address classification from the address map, written arithmetically.
  function automatic void classify(input logic [31:0] a, output int kind,
                                   output int idx, output bit ureg);
    kind = K_ILL;
    idx  = 0;
    ureg = 1'b0;
    if (a % 4 != 0) return;
    if (a >= 32'h1000 && a < 32'h13FC) begin
      kind = K_RAM;
      idx  = int'((a - 32'h1000) / 4);
      return;
    end
    if (a == 32'h2004) kind = K_LED;
    if (a == 32'h2008) kind = K_SEG;
    for (int u = 0; u < 3; u++)
      for (int r = 0; r < 2; r++)
        if (a == 32'(32'h2010 + 16 * u + 8 * r)) begin
          kind = K_UART;
          idx  = u;
          ureg = (r == 1);
        end
  endfunction

  function automatic void resetModel();
    m_wdata = 0; m_led = 0; m_seg = 0; m_err_addr = 0;
    m_ram_idx = 0; m_ureg = 0; m_err = 0;
  endfunction

  function automatic vec_t stepModel(bit we, logic [31:0] addr,
                                     logic [31:0] wdata, bit clr);
    vec_t e;
    int kind, idx;
    bit ureg, bad;
    e.we = we; e.addr = addr; e.wdata = wdata; e.clr = clr;
    e.ram_we = 0; e.uart_we = 0; e.chk_wdata = 0;
    bad = 0;
    if (we) begin
      classify(addr, kind, idx, ureg);
      case (kind)
        K_RAM:  begin e.ram_we = 1; m_ram_idx = 8'(idx); m_wdata = wdata; end
        K_LED:  m_led = wdata;
        K_SEG:  m_seg = wdata;
        K_UART: begin e.uart_we = 3'(1 << idx); m_ureg = ureg; m_wdata = wdata; end
        default: begin
          bad = 1;
          if (!m_err || clr) begin m_err = 1; m_err_addr = addr; end
        end
      endcase
    end
    if (clr && !bad) begin m_err = 0; m_err_addr = 0; end
    e.ram_addr = m_ram_idx; e.uart_reg = m_ureg; e.led = m_led; e.seg = m_seg;
    e.err = m_err; e.err_addr = m_err_addr;
    e.chk_wdata = e.ram_we || (e.uart_we != 0);
    e.wdata_exp = m_wdata;
    return e;
  endfunction

  initial begin
    vec_t rv;
    rst_n = 1'b0;
    bus_if.we = 0; bus_if.addr = 0; bus_if.wdata = 0; err_clr = 0;

    //      we addr      wdata         clr rwe ridx uwe    ur led    seg    err eaddr     chk wexp
    addVec(1, 32'h1000, 32'hAAAA5555, 0, 1, 0,   3'b000, 0, 32'h0,  32'h0,  0, 32'h0,    1, 32'hAAAA5555);
    addVec(1, 32'h13F8, 32'h11111111, 0, 1, 254, 3'b000, 0, 32'h0,  32'h0,  0, 32'h0,    1, 32'h11111111);
    addVec(1, 32'h13FC, 32'h22222222, 0, 0, 254, 3'b000, 0, 32'h0,  32'h0,  1, 32'h13FC, 0, 32'h0);
    addVec(1, 32'h0FFC, 32'h0,        0, 0, 254, 3'b000, 0, 32'h0,  32'h0,  1, 32'h13FC, 0, 32'h0);
    addVec(0, 32'h0,    32'h0,        1, 0, 254, 3'b000, 0, 32'h0,  32'h0,  0, 32'h0,    0, 32'h0);
    addVec(1, 32'h2004, 32'hF0,       0, 0, 254, 3'b000, 0, 32'hF0, 32'h0,  0, 32'h0,    0, 32'h0);
    addVec(1, 32'h2008, 32'h7F,       0, 0, 254, 3'b000, 0, 32'hF0, 32'h7F, 0, 32'h0,    0, 32'h0);
    addVec(1, 32'h2028, 32'h41,       0, 0, 254, 3'b010, 1, 32'hF0, 32'h7F, 0, 32'h0,    1, 32'h41);
    addVec(1, 32'h2030, 32'h42,       0, 0, 254, 3'b100, 0, 32'hF0, 32'h7F, 0, 32'h0,    1, 32'h42);
    addVec(1, 32'h203C, 32'h43,       0, 0, 254, 3'b000, 0, 32'hF0, 32'h7F, 1, 32'h203C, 0, 32'h0);
    addVec(0, 32'h0,    32'h0,        1, 0, 254, 3'b000, 0, 32'hF0, 32'h7F, 0, 32'h0,    0, 32'h0);
    addVec(1, 32'h2000, 32'h1,        0, 0, 254, 3'b000, 0, 32'hF0, 32'h7F, 1, 32'h2000, 0, 32'h0);
    addVec(1, 32'h3000, 32'h2,        0, 0, 254, 3'b000, 0, 32'hF0, 32'h7F, 1, 32'h2000, 0, 32'h0);
    addVec(1, 32'h1002, 32'h3,        0, 0, 254, 3'b000, 0, 32'hF0, 32'h7F, 1, 32'h2000, 0, 32'h0);
    addVec(1, 32'h5000, 32'h4,        1, 0, 254, 3'b000, 0, 32'hF0, 32'h7F, 1, 32'h5000, 0, 32'h0);
    addVec(0, 32'h0,    32'h0,        1, 0, 254, 3'b000, 0, 32'hF0, 32'h7F, 0, 32'h0,    0, 32'h0);
    addVec(1, 32'h1000, 32'h100,      0, 1, 0,   3'b000, 0, 32'hF0, 32'h7F, 0, 32'h0,    1, 32'h100);
    addVec(1, 32'h1004, 32'h101,      0, 1, 1,   3'b000, 0, 32'hF0, 32'h7F, 0, 32'h0,    1, 32'h101);
    addVec(1, 32'h1008, 32'h102,      0, 1, 2,   3'b000, 0, 32'hF0, 32'h7F, 0, 32'h0,    1, 32'h102);
    addVec(1, 32'h100C, 32'h103,      0, 1, 3,   3'b000, 0, 32'hF0, 32'h7F, 0, 32'h0,    1, 32'h103);
    addVec(0, 32'h100C, 32'h0,        0, 0, 3,   3'b000, 0, 32'hF0, 32'h7F, 0, 32'h0,    0, 32'h0);
    addVec(1, 32'h2018, 32'h55,       0, 0, 3,   3'b001, 1, 32'hF0, 32'h7F, 0, 32'h0,    1, 32'h55);
    addVec(1, 32'h2010, 32'h56,       0, 0, 3,   3'b001, 0, 32'hF0, 32'h7F, 0, 32'h0,    1, 32'h56);
    addVec(1, 32'h2038, 32'h57,       0, 0, 3,   3'b100, 1, 32'hF0, 32'h7F, 0, 32'h0,    1, 32'h57);
    addVec(1, 32'h2020, 32'h58,       0, 0, 3,   3'b010, 0, 32'hF0, 32'h7F, 0, 32'h0,    1, 32'h58);
    addVec(1, 32'h2001, 32'h59,       0, 0, 3,   3'b000, 0, 32'hF0, 32'h7F, 1, 32'h2001, 0, 32'h0);
    addVec(1, 32'h201C, 32'h5A,       0, 0, 3,   3'b000, 0, 32'hF0, 32'h7F, 1, 32'h2001, 0, 32'h0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset values before any store
    addVec(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1, 0);
    rv = vecs.pop_back();
    checkOutput("reset", rv);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset in the middle of traffic: a strobe is visible, another store is
    // pending, and the reset must clear everything immediately.
    applyStimulus(1, 32'h1004, 32'h77, 0);
    checkVal("pre-reset ram_we", 32'(ram_we_o), 32'h1);
    bus_if.we = 1; bus_if.addr = 32'h2004; bus_if.wdata = 32'h99;
    #2 rst_n = 1'b0;
    #1 checkOutput("async reset", rv);
    @(posedge clk);
    @(negedge clk);
    bus_if.we = 0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("post reset idle", rv);

    // Randomized stores against the reference model
    resetModel();
    for (int i = 0; i < 400; i++) begin
      bit          we, clr;
      logic [31:0] addr, wdata;
      vec_t        e;
      we    = ($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 9) == 0);
      wdata = $urandom;
      case ($urandom_range(0, 4))
        0: addr = 32'h1000 + 4 * $urandom_range(0, 254);
        1: addr = edge_list[$urandom_range(0, 3)];
        2: addr = periph_list[$urandom_range(0, 11)];
        3: addr = ((32'h1000 + $urandom_range(0, 4095)) & ~32'h3) | 32'($urandom_range(1, 3));
        default: addr = $urandom;
      endcase
      e = stepModel(we, addr, wdata, clr);
      applyStimulus(we, addr, wdata, clr);
      checkOutput($sformatf("rand%0d", i), e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
